pma_arbiter: RTL
================

PMA_ARBITER -- requirements
Module: pma_arbiter

Interface
REQ-001 SHALL have parameter PA_BITS, default 34, physical address width.
REQ-002 SHALL have parameter FCNT_BITS, default 8, fault-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports IReqValid input 1, IReqReady output 1, IReqAdr input PA_BITS; this is the fetch request.
REQ-006 SHALL have ports DReqValid input 1, DReqReady output 1, DReqAdr input PA_BITS, DReqSize input 2, DReqRead/DReqWrite/DReqAtomic input 1 each; this is the data request.
REQ-007 SHALL have checker-side outputs ChkAdr PA_BITS, ChkSize 2, ChkExecute/ChkRead/ChkWrite/ChkAtomic 1 each.
REQ-008 SHALL have checker-side inputs ChkCacheable, ChkIdempotent, ChkSelTIM, ChkInstrFault, ChkLoadFault, ChkStoreAmoFault, 1 each.
REQ-009 SHALL have ports IRspValid output 1, IRspReady input 1, IRspFault/IRspCacheable/IRspSelTIM output 1 each.
REQ-010 SHALL have ports DRspValid output 1, DRspReady input 1, DRspLoadFault/DRspStoreAmoFault/DRspCacheable/DRspIdempotent/DRspSelTIM output 1 each.
REQ-011 SHALL have ports FaultCount output FCNT_BITS and FaultClr input 1.

Function
REQ-012 SHALL use a single shared PMA checker with at most one outstanding transaction total.
REQ-013 SHALL implement FSM states IDLE, CHECK, RESP.
REQ-014 IDLE: IReqReady/DReqReady SHALL be combinational grant signals; a handshake is valid&ready; on a handshake the FSM SHALL latch the address and attributes and go to CHECK; with no request it SHALL stay in IDLE.
REQ-015 Ready SHALL be 0 for both requesters in CHECK and RESP.
REQ-016 CHECK: Chk* outputs SHALL be driven from the latched request, and checker results SHALL be registered at the end of the cycle; the FSM SHALL then go to RESP.
REQ-017 Fetch transactions SHALL drive ChkExecute=1, ChkSize=2'b10 and ChkRead/ChkWrite/ChkAtomic=0; data transactions SHALL drive ChkExecute=0 and pass Size/Read/Write/Atomic through.
REQ-018 Outside CHECK, ChkExecute/ChkRead/ChkWrite/ChkAtomic SHALL be 0.
REQ-019 RESP: only the owning requester's RspValid SHALL be 1, and its fields SHALL stay stable until RspReady; on valid&ready the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be: handshake in cycle N, CHECK in N+1, RspValid first asserted in N+2.
REQ-021 IRspFault SHALL equal the registered ChkInstrFault; DRspLoadFault and DRspStoreAmoFault SHALL equal the registered checker values.
REQ-022 Response fields SHALL be 0 whenever the corresponding RspValid is 0.
REQ-023 FaultCount SHALL increment by 1 at each response handshake carrying any fault, SHALL saturate at all-ones, and SHALL clear on FaultClr.
REQ-024 If FaultClr and a faulting handshake occur in the same cycle, FaultCount SHALL become 0.
REQ-025 Requesters SHALL hold Valid and fields stable until Ready; the arbiter SHALL NOT depend on a dropped Valid.

Reset
REQ-026 Reset SHALL asynchronously force state IDLE, FaultCount=0, IRspValid=DRspValid=0, all response fields 0, and the round-robin pointer to "data next".
REQ-027 Reset asserted in CHECK or RESP SHALL discard the transaction with no response.
REQ-028 After reset deasserts, the first rising edge SHALL be able to accept a handshake.

Configuration
REQ-029 Macro PMAARB_ROUND_ROBIN_EN defined: on simultaneous IReqValid and DReqValid, the grant SHALL alternate, and the pointer SHALL update only on a granted handshake.
REQ-030 Macro PMAARB_ROUND_ROBIN_EN undefined: data SHALL have fixed priority over fetch, and no pointer state SHALL exist.
REQ-031 A lone requester SHALL always be granted in IDLE in either configuration.

Verification
REQ-032 Fetch only: IReqAdr=0x8000_0000, checker faults 0 -> IReqReady=1 in cycle N, ChkExecute=1 in N+1, IRspValid=1 and IRspFault=0 in N+2.
REQ-033 Simultaneous I and D requests for 4 transactions with the macro defined -> grant order D,I,D,I; with the macro undefined -> D,D,D,D while D is held valid.
REQ-034 D atomic with ChkStoreAmoFault=1 and DRspReady held 0 for 5 cycles -> DRspValid and DRspStoreAmoFault stay 1 for 5 cycles, both Readys are 0, and FaultCount increments only at the handshake.
REQ-035 Reset pulsed during CHECK -> no RspValid afterward, state IDLE, and the next request completes normally.
REQ-036 FCNT_BITS=2 with 5 faulting responses -> FaultCount 1,2,3,3,3; FaultClr coinciding with a fault -> 0.

Source files
------------

// File: rtl/pma_arbiter_if.sv
// pma_arbiter_if -- bundle of every request, checker, response and fault-counter
// signal of pma_arbiter.
//   slave  : arbiter side (receives requests and checker results,
//            drives readies, checker attributes, responses and FaultCount)
//   master : environment side (requesters, PMA checker, response consumers)
// Parameters: PA_BITS physical address width, FCNT_BITS fault-counter width.
interface pma_arbiter_if #(
   parameter int PA_BITS   = 34,
   parameter int FCNT_BITS = 8
);
   // fetch request
   logic               IReqValid;
   logic               IReqReady;
   logic [PA_BITS-1:0] IReqAdr;
   // data request
   logic               DReqValid;
   logic               DReqReady;
   logic [PA_BITS-1:0] DReqAdr;
   logic [1:0]         DReqSize;
   logic               DReqRead;
   logic               DReqWrite;
   logic               DReqAtomic;
   // shared PMA checker
   logic [PA_BITS-1:0] ChkAdr;
   logic [1:0]         ChkSize;
   logic               ChkExecute;
   logic               ChkRead;
   logic               ChkWrite;
   logic               ChkAtomic;
   logic               ChkCacheable;
   logic               ChkIdempotent;
   logic               ChkSelTIM;
   logic               ChkInstrFault;
   logic               ChkLoadFault;
   logic               ChkStoreAmoFault;
   // fetch response
   logic               IRspValid;
   logic               IRspReady;
   logic               IRspFault;
   logic               IRspCacheable;
   logic               IRspSelTIM;
   // data response
   logic               DRspValid;
   logic               DRspReady;
   logic               DRspLoadFault;
   logic               DRspStoreAmoFault;
   logic               DRspCacheable;
   logic               DRspIdempotent;
   logic               DRspSelTIM;
   // fault counter
   logic [FCNT_BITS-1:0] FaultCount;
   logic                 FaultClr;

   modport slave (
      input  IReqValid, IReqAdr,
      output IReqReady,
      input  DReqValid, DReqAdr, DReqSize, DReqRead, DReqWrite, DReqAtomic,
      output DReqReady,
      output ChkAdr, ChkSize, ChkExecute, ChkRead, ChkWrite, ChkAtomic,
      input  ChkCacheable, ChkIdempotent, ChkSelTIM,
      input  ChkInstrFault, ChkLoadFault, ChkStoreAmoFault,
      output IRspValid, IRspFault, IRspCacheable, IRspSelTIM,
      input  IRspReady,
      output DRspValid, DRspLoadFault, DRspStoreAmoFault,
      output DRspCacheable, DRspIdempotent, DRspSelTIM,
      input  DRspReady,
      output FaultCount,
      input  FaultClr
   );

   modport master (
      output IReqValid, IReqAdr,
      input  IReqReady,
      output DReqValid, DReqAdr, DReqSize, DReqRead, DReqWrite, DReqAtomic,
      input  DReqReady,
      input  ChkAdr, ChkSize, ChkExecute, ChkRead, ChkWrite, ChkAtomic,
      output ChkCacheable, ChkIdempotent, ChkSelTIM,
      output ChkInstrFault, ChkLoadFault, ChkStoreAmoFault,
      input  IRspValid, IRspFault, IRspCacheable, IRspSelTIM,
      output IRspReady,
      input  DRspValid, DRspLoadFault, DRspStoreAmoFault,
      input  DRspCacheable, DRspIdempotent, DRspSelTIM,
      output DRspReady,
      input  FaultCount,
      output FaultClr
   );
endinterface

// File: rtl/pma_arbiter.sv
// pma_arbiter -- shares one PMA checker between the fetch (I) and data (D)
// requesters with at most one transaction in flight.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pma_arbiter_if.slave (requests, checker, responses, FaultCount)
// Flow: IDLE (grant + latch) -> CHECK (checker driven, result registered)
//       -> RESP (owner's RspValid held until RspReady) -> IDLE.
// Build option: PMAARB_ROUND_ROBIN_EN defined alternates the grant between
// simultaneous requesters; undefined gives data fixed priority.
module pma_arbiter #(
   parameter int PA_BITS   = 34,
   parameter int FCNT_BITS = 8
) (
   input  logic          clk,
   input  logic          reset,
   pma_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

   state_t               state;
   logic                 ownerD;
   logic [PA_BITS-1:0]   adrQ;
   logic [1:0]           sizeQ;
   logic                 exeQ, rdQ, wrQ, atQ;
   logic                 iRspValid, iRspFault, iRspCache, iRspTim;
   logic                 dRspValid, dLoadF, dStoreF, dCache, dIdem, dTim;
   logic [FCNT_BITS-1:0] faultCount;

   logic                 dataWin;
   logic                 grantI, grantD;
   logic                 rspHs, rspFault;

`ifdef PMAARB_ROUND_ROBIN_EN
   logic                 dataNext;

   always_comb dataWin = bus.DReqValid && (!bus.IReqValid || dataNext);
`else
   always_comb dataWin = bus.DReqValid;
`endif

   always_comb begin
      grantD   = (state == IDLE) && dataWin;
      grantI   = (state == IDLE) && bus.IReqValid && !dataWin;
      rspHs    = (iRspValid && bus.IRspReady) || (dRspValid && bus.DRspReady);
      // non-owner fields are held at zero, so OR-ing them is safe
      rspFault = iRspFault || dLoadF || dStoreF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ownerD     <= 1'b0;
         adrQ       <= '0;
         sizeQ      <= '0;
         exeQ       <= 1'b0;
         rdQ        <= 1'b0;
         wrQ        <= 1'b0;
         atQ        <= 1'b0;
         iRspValid  <= 1'b0;
         iRspFault  <= 1'b0;
         iRspCache  <= 1'b0;
         iRspTim    <= 1'b0;
         dRspValid  <= 1'b0;
         dLoadF     <= 1'b0;
         dStoreF    <= 1'b0;
         dCache     <= 1'b0;
         dIdem      <= 1'b0;
         dTim       <= 1'b0;
         faultCount <= '0;
`ifdef PMAARB_ROUND_ROBIN_EN
         dataNext   <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (grantD || grantI) begin
                  ownerD <= grantD;
                  adrQ   <= grantD ? bus.DReqAdr : bus.IReqAdr;
                  // fetches are always checked as 32-bit executes
                  sizeQ  <= grantD ? bus.DReqSize : 2'b10;
                  exeQ   <= grantI;
                  rdQ    <= grantD && bus.DReqRead;
                  wrQ    <= grantD && bus.DReqWrite;
                  atQ    <= grantD && bus.DReqAtomic;
                  state  <= CHECK;
`ifdef PMAARB_ROUND_ROBIN_EN
                  dataNext <= grantI;
`endif
               end
            end
            CHECK: begin
               exeQ <= 1'b0;
               rdQ  <= 1'b0;
               wrQ  <= 1'b0;
               atQ  <= 1'b0;
               if (ownerD) begin
                  dRspValid <= 1'b1;
                  dLoadF    <= bus.ChkLoadFault;
                  dStoreF   <= bus.ChkStoreAmoFault;
                  dCache    <= bus.ChkCacheable;
                  dIdem     <= bus.ChkIdempotent;
                  dTim      <= bus.ChkSelTIM;
               end else begin
                  iRspValid <= 1'b1;
                  iRspFault <= bus.ChkInstrFault;
                  iRspCache <= bus.ChkCacheable;
                  iRspTim   <= bus.ChkSelTIM;
               end
               state <= RESP;
            end
            RESP: begin
               if (rspHs) begin
                  iRspValid <= 1'b0;
                  iRspFault <= 1'b0;
                  iRspCache <= 1'b0;
                  iRspTim   <= 1'b0;
                  dRspValid <= 1'b0;
                  dLoadF    <= 1'b0;
                  dStoreF   <= 1'b0;
                  dCache    <= 1'b0;
                  dIdem     <= 1'b0;
                  dTim      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // clear dominates a simultaneous faulting handshake
         if (bus.FaultClr)
            faultCount <= '0;
         else if (rspHs && rspFault && (faultCount != '1))
            faultCount <= faultCount + FCNT_BITS'(1);
      end
   end

   assign bus.IReqReady         = grantI;
   assign bus.DReqReady         = grantD;
   assign bus.ChkAdr            = adrQ;
   assign bus.ChkSize           = sizeQ;
   assign bus.ChkExecute        = exeQ;
   assign bus.ChkRead           = rdQ;
   assign bus.ChkWrite          = wrQ;
   assign bus.ChkAtomic         = atQ;
   assign bus.IRspValid         = iRspValid;
   assign bus.IRspFault         = iRspFault;
   assign bus.IRspCacheable     = iRspCache;
   assign bus.IRspSelTIM        = iRspTim;
   assign bus.DRspValid         = dRspValid;
   assign bus.DRspLoadFault     = dLoadF;
   assign bus.DRspStoreAmoFault = dStoreF;
   assign bus.DRspCacheable     = dCache;
   assign bus.DRspIdempotent    = dIdem;
   assign bus.DRspSelTIM        = dTim;
   assign bus.FaultCount        = faultCount;

endmodule
